weight_load_ctrl: RTL and testbench
===================================

# weight_load_ctrl

Sequencer that streams the packed 64-bit weight image (1317 words: conv1–conv5 plus FC kernels, biases and per-layer scale words) from a valid/ready source into the CNN `model` weight port. It regenerates the per-layer bank-interleaved address pattern in hardware, so the host or DMA only supplies words in file order. It sits between the weight DMA/FIFO and `model.load_weight/weight_addr/weight_data`.

## Interface
- `pWEIGHT_DATA_WIDTH`, 64, width of one weight word.
- `pWEIGHT_BASE_ADDR`, 32'd0, address of conv1's first kernel row.
- `pADDR_WIDTH`, 32, width of `weight_addr`.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored unless the block is idle.
- `s_valid`  in  1  source word valid.
- `s_data`  in  pWEIGHT_DATA_WIDTH  source word, in file order.
- `s_ready`  out  1  block accepts a word when `s_valid && s_ready`.
- `load_weight`  out  1  per-word write strobe to `model`.
- `weight_addr`  out  pADDR_WIDTH  write address.
- `weight_data`  out  pWEIGHT_DATA_WIDTH  write data.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse after the last word is written.

## Operation
- **Layer table** (index 0..5 = conv1..conv5, fc), as `{kernel_words, banks, bias_words}`:
  - conv1: {54, 6, 8}
  - conv2–conv5: {288, 32, 8}
  - fc: {64, 2, 1}
- **Addressing within a layer**, with `base(L)` as the layer base:
  - Kernel word k is written to `base(L) + k/banks`; consecutive words fill banks 0..banks-1 at the same address.
  - Bias word b is written to `base(L) + kernel_words/banks + b`.
  - The single scale word goes to the next address.
- **Base addresses**: `base(L+1) = base(L) + kernel_words/banks + bias_words + 1`. With the default base this gives 0, 18, 36, 54, 72, 90; the last address is 123.
- **FSM states**: IDLE, KERNEL, BIAS, SCALE, FIN.
  - IDLE→KERNEL on `start` (layer 0).
  - KERNEL→BIAS after `kernel_words` accepts.
  - BIAS→SCALE after `bias_words` accepts.
  - SCALE→KERNEL of layer+1 after one accept, or SCALE→FIN if the layer is fc.
  - FIN→IDLE unconditionally after one cycle.
- **Counters**: `bank_cnt` (0..banks-1, wraps and increments `row_cnt`), `row_cnt`, `item_cnt`, `layer_idx`.
- `s_ready` is high in KERNEL, BIAS and SCALE only; there is no combinational path from `s_valid` to `s_ready`.
- Source stalls (`s_valid` low) freeze all counters, and `load_weight` stays low.
- A `start` that arrives while busy is ignored.
- Excess source words after FIN are not accepted.

## Timing
- Throughput is one word per cycle.
- `load_weight`, `weight_addr` and `weight_data` are registered: they update the cycle after an accept, with 1-cycle latency.
- `load_weight` is high exactly one cycle per accepted word.
- `done` pulses in FIN, one cycle after the last strobe. `busy` drops in that same cycle.
- **Reset values**: `s_ready`, `load_weight`, `busy` and `done` = 0; `weight_addr` = 0; `weight_data` = 0; FSM = IDLE; all counters = 0.
- **Reset mid-load**: the load is aborted on the next edge, no further strobes are issued, and a new `start` restarts from conv1 word 0.
- **Boundary**: the last bank of a row and a phase transition in the same cycle must advance both correctly. Example: conv1 word 53 is written to address 8, then word 54 (first bias) is written to address 9.

## Configuration
- **`WEIGHT_LOAD_CHECKSUM_EN` defined**:
  - Adds an input `exp_checksum[63:0]` and outputs `checksum[63:0]` and `checksum_err`.
  - `checksum` is the running XOR of all accepted words, cleared on `start`.
  - `checksum_err` is registered at FIN, equals `checksum != exp_checksum`, and holds until the next `start` or reset.
- **Undefined**: none of these ports or this logic exist.

## Structure
- **Package `weight_load_pkg`**: holds the layer count (6), a `layer_cfg_t` struct `{kernel_words, banks, bias_words}`, the constant layer table, the FSM state enum, and a function that computes base addresses.
- **Sub-module `weight_addr_gen`**: contains the bank/row/item counters and address arithmetic for one layer, with inputs `cfg`, `base`, `adv` and outputs `addr`, `phase_last`. The top level owns the FSM, the handshake and the output registers.

## Test plan
- **Full load**: `start`, 1317 words with `s_valid` continuously high. Expect:
  - addresses 0×6, 1×6 … 8×6, then 9..16, 17, 18×32 …, with the last word at address 123;
  - exactly 1317 strobes;
  - `done` one cycle after the last strobe.
- **Random stalls**: `s_valid` toggled at 30% density. Expect the same address/data sequence as the full load, no strobe during gaps, and `busy` held throughout.
- **Boundaries**:
  - word 62 → address 17 (conv1 scale);
  - word 63 → address 18 (conv2 bank 0);
  - word 95 → address 19;
  - word 1251 → address 90 (fc);
  - word 1315 → address 122.
- **Reset mid-load**: assert `rst` after 500 words. Expect no strobes after the reset edge and all outputs at 0. A new `start` then yields word 0 at address 0.
- **Busy start and excess data**: pulse `start` at word 100; no restart is expected. Supply a 1318th word; expect `s_ready` = 0 and no strobe.
- **Checksum** (with `WEIGHT_LOAD_CHECKSUM_EN`): load all-`0x01` words and set `exp_checksum` = `0x01`. Expect `checksum` = `0x01` (1317 is odd) and `checksum_err` = 0. Repeat with `exp_checksum` = 0; expect `checksum_err` = 1.

Source files
------------

// File: rtl/weight_load_pkg.sv
// Shared definitions for the weight-load sequencer: per-layer geometry,
// FSM encodings and the layer base-address helper.
package weight_load_pkg;

    localparam int unsigned NUM_LAYERS = 6;
    localparam int unsigned LAYER_W    = 3;

    typedef struct packed {
        logic [8:0] kernel_words;
        logic [5:0] banks;
        logic [3:0] bias_words;
    } layer_cfg_t;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_KERNEL = 3'd1;
    localparam state_t S_BIAS   = 3'd2;
    localparam state_t S_SCALE  = 3'd3;
    localparam state_t S_FIN    = 3'd4;

    // Layer 0 is conv1, 1..4 are conv2..conv5, 5 is the fully connected layer.
    function automatic layer_cfg_t layer_cfg(input logic [LAYER_W-1:0] idx);
        layer_cfg_t c;
        case (idx)
            3'd0:    c = '{kernel_words: 9'd54,  banks: 6'd6,  bias_words: 4'd8};
            3'd5:    c = '{kernel_words: 9'd64,  banks: 6'd2,  bias_words: 4'd1};
            default: c = '{kernel_words: 9'd288, banks: 6'd32, bias_words: 4'd8};
        endcase
        return c;
    endfunction

    // Offset of a layer's first row from the weight base: the sum of the
    // address spans (rows + biases + scale) of every earlier layer.
    function automatic logic [15:0] layer_base_off(input logic [LAYER_W-1:0] idx);
        logic [15:0] off;
        layer_cfg_t  c;
        off = '0;
        for (int unsigned l = 0; l < NUM_LAYERS; l++) begin
            c = layer_cfg(LAYER_W'(l));
            if (LAYER_W'(l) < idx)
                off = off + 16'(c.kernel_words / 9'(c.banks)) + 16'(c.bias_words) + 16'd1;
        end
        return off;
    endfunction

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Source handshake plus model weight-port bus; the controller takes the
// slave side, the source/model environment the master side.
interface weight_load_ctrl_if #(
    parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
    parameter int unsigned pADDR_WIDTH        = 32
);
    logic                          s_valid;
    logic [pWEIGHT_DATA_WIDTH-1:0] s_data;
    logic                          s_ready;
    logic                          load_weight;
    logic [pADDR_WIDTH-1:0]        weight_addr;
    logic [pWEIGHT_DATA_WIDTH-1:0] weight_data;

    modport master (
        output s_valid, s_data,
        input  s_ready, load_weight, weight_addr, weight_data
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, load_weight, weight_addr, weight_data
    );
endinterface

// File: rtl/weight_addr_gen.sv
// Per-layer bank/row/item counters producing the bank-interleaved write
// address for the current word of one layer.
module weight_addr_gen
    import weight_load_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  layer_cfg_t             cfg,
    input  logic [pADDR_WIDTH-1:0] base,
    input  logic                   adv,
    output logic [pADDR_WIDTH-1:0] addr,
    output logic                   phase_last
);
    logic [5:0] bank_cnt;
    logic [8:0] row_cnt;
    logic [8:0] item_cnt;
    logic [8:0] kb_end;
    logic       in_kernel;
    logic       layer_last;

    // row_cnt keeps counting through bias and scale words, so the address
    // is always base + row_cnt and no divider is needed.
    always_comb begin
        kb_end     = cfg.kernel_words + 9'(cfg.bias_words);
        in_kernel  = item_cnt < cfg.kernel_words;
        layer_last = item_cnt == kb_end;
        phase_last = (item_cnt == cfg.kernel_words - 9'd1) ||
                     (item_cnt == kb_end - 9'd1) || layer_last;
        addr       = base + pADDR_WIDTH'(row_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst || clr || (adv && layer_last)) begin
            bank_cnt <= '0;
            row_cnt  <= '0;
            item_cnt <= '0;
        end else if (adv) begin
            item_cnt <= item_cnt + 9'd1;
            if (!in_kernel) begin
                row_cnt <= row_cnt + 9'd1;
            end else if (bank_cnt == cfg.banks - 6'd1) begin
                bank_cnt <= '0;
                row_cnt  <= row_cnt + 9'd1;
            end else begin
                bank_cnt <= bank_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/weight_load_ctrl.sv
// Streams the packed weight image from a valid/ready source into the model
// weight port. Optional running-XOR check under WEIGHT_LOAD_CHECKSUM_EN.
module weight_load_ctrl
    import weight_load_pkg::*;
#(
    parameter int unsigned            pWEIGHT_DATA_WIDTH = 64,
    parameter int unsigned            pADDR_WIDTH        = 32,
    parameter logic [pADDR_WIDTH-1:0] pWEIGHT_BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    input  logic [63:0]       exp_checksum,
    output logic [63:0]       checksum,
    output logic              checksum_err,
`endif
    output logic              busy,
    output logic              done,
    weight_load_ctrl_if.slave wl
);
    state_t                 state;
    logic [LAYER_W-1:0]     layer_idx;
    layer_cfg_t             cfg;
    logic [pADDR_WIDTH-1:0] base;
    logic [pADDR_WIDTH-1:0] gen_addr;
    logic                   phase_last;
    logic                   accept;
    logic                   launch;

    always_comb begin
        cfg        = layer_cfg(layer_idx);
        base       = pWEIGHT_BASE_ADDR + pADDR_WIDTH'(layer_base_off(layer_idx));
        wl.s_ready = (state == S_KERNEL) || (state == S_BIAS) || (state == S_SCALE);
        accept     = wl.s_valid && wl.s_ready;
        launch     = start && (state == S_IDLE);
    end

    weight_addr_gen #(
        .pADDR_WIDTH(pADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clr        (launch),
        .cfg        (cfg),
        .base       (base),
        .adv        (accept),
        .addr       (gen_addr),
        .phase_last (phase_last)
    );

    // done is registered off FIN so it trails the final strobe by one cycle;
    // busy falls on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            layer_idx      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            wl.load_weight <= 1'b0;
            wl.weight_addr <= '0;
            wl.weight_data <= '0;
        end else begin
            done           <= (state == S_FIN);
            wl.load_weight <= accept;
            if (accept) begin
                wl.weight_addr <= gen_addr;
                wl.weight_data <= wl.s_data;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_KERNEL;
                        layer_idx <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_KERNEL: if (accept && phase_last) state <= S_BIAS;
                S_BIAS:   if (accept && phase_last) state <= S_SCALE;
                S_SCALE: begin
                    if (accept) begin
                        if (layer_idx == LAYER_W'(NUM_LAYERS - 1)) begin
                            state <= S_FIN;
                        end else begin
                            layer_idx <= layer_idx + 3'd1;
                            state     <= S_KERNEL;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            checksum     <= '0;
            checksum_err <= 1'b0;
        end else begin
            if (accept)
                checksum <= checksum ^ 64'(wl.s_data);
            if (state == S_FIN)
                checksum_err <= (checksum != exp_checksum);
        end
    end
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl: full load, stalled load with a
// busy-time start, reset mid-load, excess data and (optional) checksum.
module tb_weight_load_ctrl;
    localparam int unsigned DW      = 64;
    localparam int unsigned AW      = 32;
    localparam int          N_WORDS = 1317;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    logic [63:0] exp_checksum;
    logic [63:0] checksum;
    logic        checksum_err;
`endif

    weight_load_ctrl_if #(.pWEIGHT_DATA_WIDTH(DW), .pADDR_WIDTH(AW)) wl_if ();

    weight_load_ctrl #(
        .pWEIGHT_DATA_WIDTH (DW),
        .pADDR_WIDTH        (AW),
        .pWEIGHT_BASE_ADDR  (32'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        .exp_checksum (exp_checksum),
        .checksum     (checksum),
        .checksum_err (checksum_err),
`endif
        .busy         (busy),
        .done         (done),
        .wl           (wl_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int kw_tab [6] = '{54, 288, 288, 288, 288, 64};
    int nb_tab [6] = '{6, 32, 32, 32, 32, 2};
    int bw_tab [6] = '{8, 8, 8, 8, 8, 1};

    int bnd_word [11] = '{0, 5, 6, 53, 54, 62, 63, 95, 1251, 1315, 1316};
    int bnd_addr [11] = '{0, 0, 1, 8,  9,  17, 18, 19, 90,   122,  123};

    logic [31:0] addr_q [$];
    logic [63:0] data_q [$];
    int strobe_cnt, bad_strobe, busy_gap, done_cnt;
    int cyc = 0, last_strobe_cyc = 0, done_cyc = 0;
    int next_idx;
    bit acc_prev  = 1'b0;
    bit in_load   = 1'b0;
    bit ones_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] word_val(input int n);
        if (ones_mode) return 64'h1;
        return {32'hC0FFEE00 ^ 32'(n), 32'(n)};
    endfunction

    function automatic int exp_addr(input int n);
        int r = n;
        int b = 0;
        for (int l = 0; l < 6; l++) begin
            if (r < kw_tab[l]) return b + r / nb_tab[l];
            if (r <= kw_tab[l] + bw_tab[l]) return b + kw_tab[l] / nb_tab[l] + (r - kw_tab[l]);
            r -= kw_tab[l] + bw_tab[l] + 1;
            b += kw_tab[l] / nb_tab[l] + bw_tab[l] + 1;
        end
        return -1;
    endfunction

    function automatic logic [63:0] q_addr(input int i);
        if (i < addr_q.size()) return 64'(addr_q[i]);
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] q_data(input int i);
        if (i < data_q.size()) return data_q[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (wl_if.load_weight) begin
            addr_q.push_back(wl_if.weight_addr);
            data_q.push_back(wl_if.weight_data);
            strobe_cnt++;
            last_strobe_cyc = cyc;
            if (!acc_prev) bad_strobe++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            in_load  = 1'b0;
        end else if (in_load && !busy) begin
            busy_gap++;
        end
        acc_prev = wl_if.s_valid && wl_if.s_ready;
    end

    task automatic clear_capture();
        addr_q.delete();
        data_q.delete();
        strobe_cnt = 0;
        bad_strobe = 0;
        busy_gap   = 0;
        done_cnt   = 0;
        next_idx   = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        in_load = 1'b1;
    endtask

    task automatic drive_words(input int n, input int stall_pct);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 10000) begin
            wl_if.s_valid = ($urandom_range(99) >= stall_pct);
            wl_if.s_data  = word_val(next_idx);
            @(negedge clk);
            if (wl_if.s_valid && wl_if.s_ready) begin
                sent++;
                next_idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        wl_if.s_valid = 1'b0;
        if (sent < n) check("drive_timeout", 64'(sent), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic load_checks(input string tag);
        int am = 0;
        int dm = 0;
        check({tag, "_strobes"}, 64'(strobe_cnt), 64'(N_WORDS));
        for (int i = 0; i < addr_q.size(); i++) begin
            if (addr_q[i] != 32'(exp_addr(i))) am++;
            if (data_q[i] != word_val(i)) dm++;
        end
        check({tag, "_addr_seq_errs"}, 64'(am), 64'd0);
        check({tag, "_data_seq_errs"}, 64'(dm), 64'd0);
        check({tag, "_gap_strobes"}, 64'(bad_strobe), 64'd0);
        check({tag, "_busy_gaps"}, 64'(busy_gap), 64'd0);
        check({tag, "_done_latency"}, 64'(done_cyc - last_strobe_cyc), 64'd1);
        for (int b = 0; b < 11; b++)
            check($sformatf("%s_word%0d_addr", tag, bnd_word[b]), q_addr(bnd_word[b]), 64'(bnd_addr[b]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        rst           = 1'b1;
        start         = 1'b0;
        wl_if.s_valid = 1'b0;
        wl_if.s_data  = '0;
`ifdef WEIGHT_LOAD_CHECKSUM_EN
        exp_checksum  = '0;
`endif
        clear_capture();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 64'(wl_if.s_ready), 64'd0);
        check("rst_load_weight", 64'(wl_if.load_weight), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'(wl_if.weight_addr), 64'd0);
        check("rst_data", wl_if.weight_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full load, source never stalls, then offer a 1318th word.
        clear_capture();
        pulse_start();
        drive_words(N_WORDS, 0);
        wait_done("full");
        load_checks("full");
        check("full_busy_after", 64'(busy), 64'd0);
        sc = strobe_cnt;
        wl_if.s_valid = 1'b1;
        wl_if.s_data  = word_val(N_WORDS);
        @(negedge clk);
        check("excess_s_ready", 64'(wl_if.s_ready), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("excess_strobes", 64'(strobe_cnt), 64'(sc));
        @(posedge clk); #1;
        wl_if.s_valid = 1'b0;

        // Stalled load with a start pulse issued mid-load at word 100.
        clear_capture();
        pulse_start();
        drive_words(100, 30);
        pulse_start();
        drive_words(N_WORDS - 100, 30);
        wait_done("stall");
        load_checks("stall");

        // Reset after 500 words, then restart from conv1 word 0.
        clear_capture();
        pulse_start();
        drive_words(500, 0);
        rst     = 1'b1;
        in_load = 1'b0;
        wl_if.s_valid = 1'b1;
        @(posedge clk); #1;
        sc = strobe_cnt;
        check("rstmid_strobes_before", 64'(sc), 64'd500);
        @(posedge clk);
        @(negedge clk);
        check("rstmid_load_weight", 64'(wl_if.load_weight), 64'd0);
        check("rstmid_addr", 64'(wl_if.weight_addr), 64'd0);
        check("rstmid_data", wl_if.weight_data, 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_s_ready", 64'(wl_if.s_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rstmid_no_strobes", 64'(strobe_cnt), 64'(sc));
        @(posedge clk); #1;
        wl_if.s_valid = 1'b0;
        clear_capture();
        pulse_start();
        drive_words(64, 0);
        repeat (2) @(posedge clk);
        #1;
        check("restart_strobes", 64'(strobe_cnt), 64'd64);
        check("restart_w0_addr", q_addr(0), 64'd0);
        check("restart_w0_data", q_data(0), word_val(0));
        check("restart_w63_addr", q_addr(63), 64'd18);
        in_load = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
        ones_mode    = 1'b1;
        exp_checksum = 64'h1;
        clear_capture();
        pulse_start();
        drive_words(N_WORDS, 0);
        wait_done("csum_ok");
        check("csum_ok_value", checksum, 64'h1);
        check("csum_ok_err", 64'(checksum_err), 64'd0);

        exp_checksum = 64'h0;
        clear_capture();
        pulse_start();
        drive_words(N_WORDS, 0);
        wait_done("csum_bad");
        check("csum_bad_value", checksum, 64'h1);
        check("csum_bad_err", 64'(checksum_err), 64'd1);
        ones_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
